// File: rtl/obi_bram_ctrl.sv
// obi_bram_ctrl: OBI slave that maps cv32e40p bus accesses onto a simple
// dual-port byte-write BRAM and returns fixed-latency, in-order responses.
// Ports: clk_i/rst_i; OBI req/gnt/addr/we/be/wdata -> rvalid/rdata/err;
// RAM write port a (addra/dina/wea); RAM read port b (addrb/enb/regceb/rstb/doutb);
// wrapping debug counters rd_count_o, wr_count_o, err_count_o.
module obi_bram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] ram_addra_o,
    output logic [31:0]           ram_dina_o,
    output logic [3:0]            ram_wea_o,
    output logic [ADDR_WIDTH-1:0] ram_addrb_o,
    output logic                  ram_enb_o,
    output logic                  ram_regceb_o,
    output logic                  ram_rstb_o,
    input  logic [31:0]           ram_doutb_i,
    output logic [31:0]           rd_count_o,
    output logic [31:0]           wr_count_o,
    output logic [31:0]           err_count_o
);

    localparam int unsigned LAST      = RD_LATENCY - 1;
    localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_WIDTH;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("obi_bram_ctrl: RD_LATENCY must be 1 or 2");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_width
        $error("obi_bram_ctrl: ADDR_WIDTH must be 1..30");
    end

    logic [32:0]           w_off;
    logic                  w_in_range;
    logic                  w_acc;
    logic [ADDR_WIDTH-1:0] w_word;

    assign gnt_o = req_i & ~rst_i;
    assign w_acc = req_i & gnt_o;

    // 33-bit offset: an address below BASE_ADDR wraps into bit 32 and
    // can never look like an in-window hit.
    assign w_off      = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    assign w_in_range = w_off < WIN_BYTES;
    assign w_word     = w_off[ADDR_WIDTH+1:2];

    assign ram_addra_o = w_word;
    assign ram_dina_o  = wdata_i;
    assign ram_wea_o   = (w_acc & we_i & w_in_range) ? be_i : 4'h0;
    assign ram_addrb_o = w_word;
    assign ram_enb_o   = w_acc & ~we_i & w_in_range;
    assign ram_rstb_o  = rst_i;

    logic [RD_LATENCY-1:0] r_vld;
    logic [RD_LATENCY-1:0] r_rd;
    logic [RD_LATENCY-1:0] r_err;
    logic [RD_LATENCY:0]   w_vld_in;
    logic [RD_LATENCY:0]   w_rd_in;
    logic [RD_LATENCY:0]   w_err_in;
    logic [31:0]           r_rd_cnt;
    logic [31:0]           r_wr_cnt;
    logic [31:0]           r_err_cnt;

    // Bit 0 is the accept entering the pipe, the top bit the response leaving it.
    assign w_vld_in = {r_vld, w_acc};
    assign w_rd_in  = {r_rd, ~we_i};
    assign w_err_in = {r_err, ~w_in_range};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld     <= '0;
            r_rd      <= '0;
            r_err     <= '0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_vld     <= w_vld_in[LAST:0];
            r_rd      <= w_rd_in[LAST:0];
            r_err     <= w_err_in[LAST:0];
            r_rd_cnt  <= r_rd_cnt + {31'd0, w_acc & ~we_i & w_in_range};
            r_wr_cnt  <= r_wr_cnt + {31'd0, w_acc & we_i & w_in_range};
            // Counted as the error enters the last stage, so the count
            // already includes it in the cycle the response is presented.
            r_err_cnt <= r_err_cnt + {31'd0, w_vld_in[LAST] & w_err_in[LAST]};
        end
    end

    logic w_rsp_vld;
    logic w_rsp_rd;
    logic w_rsp_err;

    assign w_rsp_vld = w_vld_in[RD_LATENCY];
    assign w_rsp_rd  = w_rd_in[RD_LATENCY];
    assign w_rsp_err = w_err_in[RD_LATENCY];

    assign rvalid_o = w_rsp_vld;
    assign err_o    = w_rsp_vld & w_rsp_err;
    assign rdata_o  = (w_rsp_vld & w_rsp_rd & ~w_rsp_err) ? ram_doutb_i : 32'h0;

    // The RAM output register only exists in HIGH_PERFORMANCE mode.
    if (RD_LATENCY == 2) begin : g_hp
        assign ram_regceb_o = r_vld[0] & r_rd[0] & ~r_err[0];
    end else begin : g_ll
        assign ram_regceb_o = 1'b0;
    end

    assign rd_count_o  = r_rd_cnt;
    assign wr_count_o  = r_wr_cnt;
    assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_obi_bram_ctrl.sv
// tb_obi_bram_ctrl: two controllers (latency 1 at base 0, latency 2 at
// base 0x8000_0000) each with a BRAM model, checked against a transaction model.
module tb_obi_bram_ctrl;

    localparam int AW = 17;

    logic        clk;
    logic        rst;
    logic        req    [2];
    logic        we     [2];
    logic [31:0] addr   [2];
    logic [3:0]  be     [2];
    logic [31:0] wdata  [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic        err    [2];
    logic [AW-1:0] addra [2];
    logic [31:0] dina   [2];
    logic [3:0]  wea    [2];
    logic [AW-1:0] addrb [2];
    logic        enb    [2];
    logic        regceb [2];
    logic        rstb   [2];
    logic [31:0] doutb  [2];
    logic [31:0] rdc    [2];
    logic [31:0] wrc    [2];
    logic [31:0] erc    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int          LAT  = (g == 0) ? 1 : 2;
        localparam logic [31:0] BASE = (g == 0) ? 32'h0 : 32'h8000_0000;

        obi_bram_ctrl #(
            .ADDR_WIDTH(AW),
            .BASE_ADDR (BASE),
            .RD_LATENCY(LAT)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .req_i       (req[g]),
            .gnt_o       (gnt[g]),
            .addr_i      (addr[g]),
            .we_i        (we[g]),
            .be_i        (be[g]),
            .wdata_i     (wdata[g]),
            .rvalid_o    (rvalid[g]),
            .rdata_o     (rdata[g]),
            .err_o       (err[g]),
            .ram_addra_o (addra[g]),
            .ram_dina_o  (dina[g]),
            .ram_wea_o   (wea[g]),
            .ram_addrb_o (addrb[g]),
            .ram_enb_o   (enb[g]),
            .ram_regceb_o(regceb[g]),
            .ram_rstb_o  (rstb[g]),
            .ram_doutb_i (doutb[g]),
            .rd_count_o  (rdc[g]),
            .wr_count_o  (wrc[g]),
            .err_count_o (erc[g])
        );

        logic [31:0] mem [0:(1<<AW)-1];
        logic [31:0] r_q1;
        logic [31:0] r_q2;

        always @(posedge clk) begin
            for (int b = 0; b < 4; b++)
                if (wea[g][b]) mem[addra[g]][8*b +: 8] <= dina[g][8*b +: 8];
            if (enb[g]) r_q1 <= mem[addrb[g]];
            if (rstb[g]) r_q2 <= 32'h0;
            else if (regceb[g]) r_q2 <= r_q1;
        end

        assign doutb[g] = (LAT == 1) ? r_q1 : r_q2;
    end

    typedef struct {
        int          due;
        logic        rd;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        expq [2][$];
    logic [31:0] ref_mem [longint];
    int unsigned m_rd [2];
    int unsigned m_wr [2];
    int unsigned m_er [2];
    int          n_chk;
    int          n_err;
    int          cyc;

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic longint base_of(int d);
        return (d == 0) ? 64'h0 : 64'h8000_0000;
    endfunction

    task automatic chk(int d, string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d] cycle %0d: got %h expected %h",
                     nm, d, cyc, act, exp);
        end
    endtask

    task automatic check_dut(int d);
        longint      a;
        longint      win;
        longint      word;
        longint      key;
        bit          inr;
        bit          ev;
        bit          rc;
        logic [31:0] cur;
        rsp_t        r;

        chk(d, "ram_rstb", 32'(rstb[d]), 32'(rst));
        if (rst) begin
            chk(d, "rst_gnt", 32'(gnt[d]), 32'h0);
            chk(d, "rst_rvalid", 32'(rvalid[d]), 32'h0);
            chk(d, "rst_err", 32'(err[d]), 32'h0);
            chk(d, "rst_rdata", rdata[d], 32'h0);
            chk(d, "rst_rdcnt", rdc[d], 32'h0);
            chk(d, "rst_wrcnt", wrc[d], 32'h0);
            chk(d, "rst_errcnt", erc[d], 32'h0);
            chk(d, "rst_wea", 32'(wea[d]), 32'h0);
            chk(d, "rst_enb", 32'(enb[d]), 32'h0);
            expq[d].delete();
            m_rd[d] = 0;
            m_wr[d] = 0;
            m_er[d] = 0;
            return;
        end

        chk(d, "gnt", 32'(gnt[d]), 32'(req[d]));

        ev = (expq[d].size() > 0) && (expq[d][0].due == cyc);
        chk(d, "rvalid", 32'(rvalid[d]), 32'(ev));
        if (ev) begin
            r = expq[d].pop_front();
            chk(d, "err", 32'(err[d]), 32'(r.err));
            chk(d, "rdata", rdata[d], r.data);
            if (r.err) m_er[d]++;
        end

        chk(d, "rd_count", rdc[d], m_rd[d]);
        chk(d, "wr_count", wrc[d], m_wr[d]);
        chk(d, "err_count", erc[d], m_er[d]);

        rc = 1'b0;
        if (lat_of(d) == 2)
            for (int i = 0; i < expq[d].size(); i++)
                if (expq[d][i].due == cyc + 1 && expq[d][i].rd && !expq[d][i].err)
                    rc = 1'b1;
        chk(d, "regceb", 32'(regceb[d]), 32'(rc));

        if (req[d]) begin
            a    = longint'(addr[d]);
            win  = 4 * (longint'(1) << AW);
            inr  = (a >= base_of(d)) && (a < base_of(d) + win);
            word = inr ? (a - base_of(d)) / 4 : 0;
            key  = longint'(d) * (longint'(1) << 32) + word;
            chk(d, "wea", 32'(wea[d]), (we[d] && inr) ? 32'(be[d]) : 32'h0);
            chk(d, "enb", 32'(enb[d]), 32'(!we[d] && inr));
            if (inr && we[d]) begin
                chk(d, "addra", 32'(addra[d]), 32'(word));
                chk(d, "dina", dina[d], wdata[d]);
            end
            if (inr && !we[d])
                chk(d, "addrb", 32'(addrb[d]), 32'(word));

            r.due  = cyc + lat_of(d);
            r.rd   = !we[d];
            r.err  = !inr;
            cur    = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
            r.data = (!we[d] && inr) ? cur : 32'h0;
            if (we[d] && inr) begin
                for (int b = 0; b < 4; b++)
                    if (be[d][b]) cur[8*b +: 8] = wdata[d][8*b +: 8];
                ref_mem[key] = cur;
                m_wr[d]++;
            end
            if (!we[d] && inr) m_rd[d]++;
            expq[d].push_back(r);
        end else begin
            chk(d, "idle_wea", 32'(wea[d]), 32'h0);
            chk(d, "idle_enb", 32'(enb[d]), 32'h0);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) check_dut(d);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int d, logic w, logic [31:0] a, logic [3:0] b, logic [31:0] wd);
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        be[d]    = b;
        wdata[d] = wd;
    endtask

    task automatic idle(int d);
        req[d]   = 1'b0;
        we[d]    = 1'b0;
        addr[d]  = 32'h0;
        be[d]    = 4'h0;
        wdata[d] = 32'h0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        rst   = 1'b1;
        idle(0);
        idle(1);
        repeat (3) step();
        rst = 1'b0;

        // reset while a read is in flight
        drv(0, 1'b0, 32'h10, 4'hF, 32'h0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk(0, "t1_rvalid", 32'(rvalid[0]), 32'h0);
        chk(0, "t1_gnt", 32'(gnt[0]), 32'h0);
        chk(0, "t1_rdcnt", rdc[0], 32'h0);
        step();
        idle(0);
        rst = 1'b0;
        step();

        // write then read the same word
        drv(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        chk(0, "t2_wea", 32'(wea[0]), 32'hF);
        chk(0, "t2_addra", 32'(addra[0]), 32'h4);
        step();
        drv(0, 1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        chk(0, "t2_wrsp_valid", 32'(rvalid[0]), 32'h1);
        chk(0, "t2_wrsp_data", rdata[0], 32'h0);
        step();
        idle(0);
        @(negedge clk);
        chk(0, "t2_rrsp_valid", 32'(rvalid[0]), 32'h1);
        chk(0, "t2_rrsp_data", rdata[0], 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk(0, "t2_after_valid", 32'(rvalid[0]), 32'h0);
        step();

        // byte-enable merge, then a be=0 write that changes nothing
        drv(0, 1'b1, 32'h10, 4'hF, 32'h11223344);
        step();
        drv(0, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD);
        step();
        drv(0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
        step();
        drv(0, 1'b0, 32'h12, 4'h0, 32'h0);
        step();
        idle(0);
        @(negedge clk);
        chk(0, "t3_merge", rdata[0], 32'h11BB33DD);
        step();

        // window edges at base 0
        drv(0, 1'b1, 32'h0007_FFFC, 4'hF, 32'h5A5A5A5A);
        step();
        drv(0, 1'b0, 32'h0007_FFFC, 4'h0, 32'h0);
        @(negedge clk);
        chk(0, "t3_last_addrb", 32'(addrb[0]), 32'h1FFFF);
        step();
        idle(0);
        @(negedge clk);
        chk(0, "t3_last_data", rdata[0], 32'h5A5A5A5A);
        step();
        drv(0, 1'b0, 32'h0008_0000, 4'h0, 32'h0);
        step();
        drv(0, 1'b1, 32'hFFFF_FFFC, 4'hF, 32'h1);
        @(negedge clk);
        chk(0, "t3_oor_err", 32'(err[0]), 32'h1);
        step();
        idle(0);
        @(negedge clk);
        chk(0, "t3_oorw_err", 32'(err[0]), 32'h1);
        chk(0, "t3_oorw_data", rdata[0], 32'h0);
        step();

        // latency 2: fill 8 words, then 8 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            drv(1, 1'b1, 32'h8000_0000 + 32'(4 * i), 4'hF, 32'hCAFE0000 + 32'(i));
            step();
        end
        idle(1);
        repeat (3) step();
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drv(1, 1'b0, 32'h8000_0000 + 32'(4 * k), 4'h0, 32'h0);
            else idle(1);
            @(negedge clk);
            chk(1, "t4_rvalid", 32'(rvalid[1]), 32'(k >= 2));
            if (k >= 2) chk(1, "t4_rdata", rdata[1], 32'hCAFE0000 + 32'(k - 2));
            chk(1, "t4_regceb", 32'(regceb[1]), 32'(k >= 1 && k <= 8));
            step();
        end

        // out-of-range at base 0x8000_0000: one past the top, one below base
        drv(1, 1'b0, 32'h8008_0000, 4'h0, 32'h0);
        @(negedge clk);
        chk(1, "t5_enb", 32'(enb[1]), 32'h0);
        chk(1, "t5_wea", 32'(wea[1]), 32'h0);
        step();
        drv(1, 1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0);
        step();
        idle(1);
        @(negedge clk);
        chk(1, "t5_rvalid", 32'(rvalid[1]), 32'h1);
        chk(1, "t5_err", 32'(err[1]), 32'h1);
        chk(1, "t5_rdata", rdata[1], 32'h0);
        chk(1, "t5_errcnt1", erc[1], 32'h1);
        step();
        @(negedge clk);
        chk(1, "t5_err2", 32'(err[1]), 32'h1);
        chk(1, "t5_errcnt2", erc[1], 32'h2);
        step();

        // preload words 0..63, then reset counters and alternate write/read
        for (int i = 0; i < 64; i++) begin
            drv(0, 1'b1, 32'(4 * i), 4'hF, 32'h0100_0000 + 32'(i));
            step();
        end
        idle(0);
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 2 == 0)
                drv(0, 1'b1, 32'(4 * ((i * 7) % 64)), 4'(i % 16),
                    32'(i) * 32'h9E3779B9);
            else
                drv(0, 1'b0, 32'(4 * ((i * 13) % 64)), 4'h0, 32'h0);
            step();
        end
        idle(0);
        step();
        step();
        @(negedge clk);
        chk(0, "t6_rdcnt", rdc[0], 32'd500);
        chk(0, "t6_wrcnt", wrc[0], 32'd500);
        chk(0, "t6_errcnt", erc[0], 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/obi_bram_ctrl.md
Name: obi_bram_ctrl

Overview:
- OBI slave front-end that turns cv32e40p instruction/data bus transactions into port signals for the simple dual-port byte-write BRAM placed directly downstream of it.
- Grants every request at once, decodes the address window, drives the write port (addra/dina/wea) and the read port (addrb/enb/regceb/rstb), and returns in-order OBI responses after a fixed latency matching the RAM output mode.
- Keeps wrapping transaction counters for debug.

Parameters:
- ADDR_WIDTH, 17, RAM word-address width; window size = 4*2^ADDR_WIDTH bytes.
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to the window size.
- RD_LATENCY, 1, 1 = RAM in LOW_LATENCY mode, 2 = RAM in HIGH_PERFORMANCE mode; other values are illegal (elaboration error).

Ports:
- clk_i  in  1  clock; also clocks the RAM.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant.
- addr_i  in  32  byte address.
- we_i  in  1  1 = write.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- err_o  out  1  response error.
- ram_addra_o  out  ADDR_WIDTH  RAM write address.
- ram_dina_o  out  32  RAM write data.
- ram_wea_o  out  4  RAM byte write enables.
- ram_addrb_o  out  ADDR_WIDTH  RAM read address.
- ram_enb_o  out  1  RAM read enable.
- ram_regceb_o  out  1  RAM output-register enable.
- ram_rstb_o  out  1  RAM output-register reset.
- ram_doutb_i  in  32  RAM read data.
- rd_count_o  out  32  accepted in-range reads.
- wr_count_o  out  32  accepted in-range writes.
- err_count_o  out  32  error responses issued.

Behaviour:
- Reset (async assert, sync-to-clock deassert handled upstream):
  - all response pipeline valid bits, err_o, rvalid_o and counters clear to 0; rdata_o = 0.
  - ram_rstb_o = rst_i (combinational); gnt_o = 0 while rst_i is high.
  - In-flight responses at reset are dropped, never delivered.
- Grant: gnt_o = req_i & ~rst_i, combinational, no wait states. Accept = req_i & gnt_o in cycle T.
- Decode:
  - in_range = (addr_i - BASE_ADDR) < 4*2^ADDR_WIDTH, computed in 33 bits (no false hit on wrap).
  - Word address = (addr_i - BASE_ADDR)[ADDR_WIDTH+1:2]; addr_i[1:0] ignored, since the core splits misaligned accesses.
- Accepted in-range write in cycle T:
  - ram_wea_o = be_i, ram_addra_o = word address, ram_dina_o = wdata_i, all in the same cycle T.
  - be_i = 0 is legal: no byte changes, response still issued.
  - Otherwise ram_wea_o = 0.
- Accepted in-range read in cycle T:
  - ram_enb_o = 1 and ram_addrb_o = word address in cycle T; otherwise ram_enb_o = 0.
- Out-of-range access: no RAM enable of any kind; flagged err in the pipeline.
- Response pipeline: RD_LATENCY-deep shift register of {valid, is_read, err}, one stage per cycle, never stalls; OBI has no rready.
  - RD_LATENCY = 1: response in T+1.
  - RD_LATENCY = 2: ram_regceb_o = stage-1 valid & is_read & ~err; response in T+2. When RD_LATENCY = 1, ram_regceb_o = 0.
- Response cycle:
  - rvalid_o = 1; err_o = stored err.
  - rdata_o = ram_doutb_i for a good read, else 32'h0 for writes and errors.
  - Writes respond with the same latency as reads, so order is preserved.
- Back-to-back: one accept per cycle sustained indefinitely; a write in T followed by a read of the same word in T+1 returns the new data (the write commits at the T edge).
- Counters: +1 on accept, wrap at 2^32. Increment rule:
  - rd_count_o / wr_count_o increment for in-range accepts only.
  - err_count_o increments when the error response issues.

Test Plan:
- Reset mid-read: accept a read, assert rst_i the next cycle -> rvalid_o stays 0, gnt_o = 0, all counters 0.
- RD_LATENCY=1, BASE=0: write 32'hDEADBEEF, be=4'hF, addr 0x10, then read 0x10 in the next cycle:
  - ram_wea_o = 4'hF and ram_addra_o = 4 during the write cycle.
  - read data DEADBEEF arrives exactly 1 cycle after its accept.
- Byte-enable merge: memory word 0x10 = 0x11223344, write 0xAABBCCDD with be=4'b0101 -> a later read returns 0x11BB33DD.
- RD_LATENCY=2: 8 back-to-back reads of consecutive words -> rvalid_o high for 8 consecutive cycles starting 2 cycles after the first accept, data in order, ram_regceb_o one cycle ahead of each response.
- Out-of-range read, BASE=0x8000_0000, ADDR_WIDTH=17, addr 0x8008_0000:
  - ram_enb_o = 0 and ram_wea_o = 0.
  - rvalid_o with err_o = 1 and rdata_o = 0; err_count_o = 1.
- Alternating write/read stream for 1000 cycles against a reference model -> zero mismatches; rd_count_o = 500, wr_count_o = 500.
